// File: rtl/lpf_stage_scheduler.sv
// Time-multiplexed two-stage I/Q IIR low-pass: one subtract/shift/add datapath
// walks I1, I2, Q1, Q2 once per ADC sample strobe and publishes all four states together.
module lpf_stage_scheduler #(
  parameter int WIDTH = 28,
  parameter int KW    = 4,
  parameter int OVR_W = 8
) (
  input  logic                    qzt_clk,
  input  logic                    reset,
  input  logic                    sample_strobe,
  input  logic [KW-1:0]           k,
  input  logic signed [WIDTH-1:0] vin_i,
  input  logic signed [WIDTH-1:0] vin_q,
  output logic signed [WIDTH-1:0] vmid_i,
  output logic signed [WIDTH-1:0] vmid_q,
  output logic signed [WIDTH-1:0] vout_i,
  output logic signed [WIDTH-1:0] vout_q,
  output logic                    busy,
  output logic                    done,
  output logic [OVR_W-1:0]        overrun_cnt,
  output logic [2:0]              dbg_state
);

  // Handshake: sample_strobe is a valid with no back-pressure. It is accepted when
  // busy=0 (IDLE or DONE), otherwise dropped and counted; done is the one-cycle result valid.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_I1   = 3'd1;
  localparam logic [2:0] S_I2   = 3'd2;
  localparam logic [2:0] S_Q1   = 3'd3;
  localparam logic [2:0] S_Q2   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]              state;
  logic                    phase;
  logic signed [WIDTH-1:0] sh_i, sh_q;
  logic [KW-1:0]           sh_k;
  logic signed [WIDTH-1:0] y_i1, y_i2, y_q1, y_q2;
  logic signed [WIDTH:0]   diff;

  logic signed [WIDTH-1:0] x_sel, y_sel, res;
  logic signed [WIDTH:0]   x_ext, y_ext, diff_next;

  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  // Stage 2 of each channel filters the freshly written stage-1 state of the same sample.
  always_comb begin
    x_sel = '0;
    y_sel = '0;
    case (state)
      S_I1:    begin x_sel = sh_i; y_sel = y_i1; end
      S_I2:    begin x_sel = y_i1; y_sel = y_i2; end
      S_Q1:    begin x_sel = sh_q; y_sel = y_q1; end
      S_Q2:    begin x_sel = y_q1; y_sel = y_q2; end
      default: begin x_sel = '0;   y_sel = '0;   end
    endcase
    x_ext     = $signed({x_sel[WIDTH-1], x_sel});
    y_ext     = $signed({y_sel[WIDTH-1], y_sel});
    diff_next = x_ext - y_ext;
    // Result lies between y and x, so dropping the extension bit is lossless.
    res       = WIDTH'(y_ext + (diff >>> sh_k));
  end

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= 1'b0;
      sh_i        <= '0;
      sh_q        <= '0;
      sh_k        <= '0;
      diff        <= '0;
      y_i1        <= '0;
      y_i2        <= '0;
      y_q1        <= '0;
      y_q2        <= '0;
      vmid_i      <= '0;
      vmid_q      <= '0;
      vout_i      <= '0;
      vout_q      <= '0;
      overrun_cnt <= '0;
    end else begin
      if (sample_strobe && busy && (overrun_cnt != '1))
        overrun_cnt <= overrun_cnt + OVR_W'(1);
      case (state)
        S_IDLE, S_DONE: begin
          phase <= 1'b0;
          if (sample_strobe) begin
            sh_i  <= vin_i;
            sh_q  <= vin_q;
            sh_k  <= k;
            state <= S_I1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_I1, S_I2, S_Q1, S_Q2: begin
          if (!phase) begin
            diff  <= diff_next;
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            case (state)
              S_I1: begin y_i1 <= res; state <= S_I2; end
              S_I2: begin y_i2 <= res; state <= S_Q1; end
              S_Q1: begin y_q1 <= res; state <= S_Q2; end
              default: begin
                // Publish all four states on the same edge so I and Q match one sample.
                y_q2   <= res;
                vout_q <= res;
                vout_i <= y_i2;
                vmid_i <= y_i1;
                vmid_q <= y_q1;
                state  <= S_DONE;
              end
            endcase
          end
        end
        default: begin
          phase <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
